// File: rtl/fu_pkg.sv
// Shared types and constants for the functional-unit dispatch block.
package fu_pkg;

   localparam int DEF_WIDTH = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT_LOW,
      ST_WAIT_HIGH,
      ST_DONE
   } state_t;

   localparam logic [1:0] OP_NAND = 2'd0;
   localparam logic [1:0] OP_NOR  = 2'd1;
   localparam logic [1:0] OP_XOR  = 2'd2;
   localparam logic [1:0] OP_NOT  = 2'd3;

   localparam logic [1:0] UNIT_ALU = 2'd0;
   localparam logic [1:0] UNIT_LOG = 2'd1;
   localparam logic [1:0] UNIT_SHF = 2'd2;
   localparam logic [1:0] UNIT_MUL = 2'd3;

endpackage

// File: rtl/fu_watchdog.sv
// Wait-phase watchdog: cleared by load, counts while count is high,
// flags expire in the cycle that would complete TIMEOUT waiting cycles.
module fu_watchdog #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic count,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || load)
         cnt <= '0;
      else if (count)
         cnt <= cnt + 1'b1;
   end

   assign expire = count && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fu_dispatch.sv
// Initiator for the cs/rdy/op_sub functional-unit handshake; all outputs registered.
// Optional watchdog enabled by defining DISPATCH_TIMEOUT_EN.
module fu_dispatch
   import fu_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int N_UNITS = 4,
   parameter int UNIT_W  = 2,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [UNIT_W-1:0]  unit_sel,
   input  logic [1:0]         op_in,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result,
   output logic               err,
   output logic [N_UNITS-1:0] cs,
   output logic [1:0]         op_sub,
   output logic [WIDTH-1:0]   A,
   output logic [WIDTH-1:0]   B,
   input  logic [N_UNITS-1:0] rdy,
   input  logic [WIDTH-1:0]   d_in
);

   state_t              state, state_n;
   logic [UNIT_W-1:0]   unit_q;
   logic [N_UNITS-1:0]  sel_onehot;
   logic                sel_ok;
   logic                rdy_sel;
   logic                capture;
   logic                err_n;

   // Loops keep out-of-range indices from ever touching the cs/rdy vectors.
   always_comb begin
      sel_onehot = '0;
      rdy_sel    = 1'b1;
      sel_ok     = 1'b0;
      for (int i = 0; i < N_UNITS; i++) begin
         if (unit_sel == UNIT_W'(i))
            sel_onehot[i] = 1'b1;
         if (unit_q == UNIT_W'(i)) begin
            rdy_sel = rdy[i];
            sel_ok  = 1'b1;
         end
      end
   end

`ifdef DISPATCH_TIMEOUT_EN
   logic wd_expire;

   fu_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .load   (state == ST_REQ),
      .count  ((state == ST_WAIT_LOW) || (state == ST_WAIT_HIGH)),
      .expire (wd_expire)
   );
`endif

   always_comb begin
      state_n = state;
      capture = 1'b0;
      err_n   = 1'b0;
      case (state)
         ST_IDLE:      if (start) state_n = ST_REQ;
         ST_REQ: begin
            if (sel_ok)
               state_n = ST_WAIT_LOW;
            else begin
`ifdef DISPATCH_TIMEOUT_EN
               state_n = ST_IDLE;
               err_n   = 1'b1;
`else
               state_n = ST_DONE;
`endif
            end
         end
         ST_WAIT_LOW:  if (!rdy_sel) state_n = ST_WAIT_HIGH;
         ST_WAIT_HIGH: begin
            if (rdy_sel) begin
               state_n = ST_DONE;
               capture = 1'b1;
            end
         end
         ST_DONE:      state_n = ST_IDLE;
         default:      state_n = ST_IDLE;
      endcase
`ifdef DISPATCH_TIMEOUT_EN
      // Expiry wins over a simultaneous rdy rise: the result is discarded.
      if (wd_expire) begin
         state_n = ST_IDLE;
         capture = 1'b0;
         err_n   = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         unit_q <= '0;
         cs     <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         result <= '0;
         op_sub <= '0;
         A      <= '0;
         B      <= '0;
      end else begin
         state <= state_n;
         busy  <= (state_n != ST_IDLE);
         done  <= (state_n == ST_DONE);
         err   <= err_n;
         cs    <= (state_n == ST_REQ) ? sel_onehot : '0;
         if (state == ST_IDLE && start) begin
            unit_q <= unit_sel;
            op_sub <= op_in;
            A      <= a_in;
            B      <= b_in;
         end
         if (capture)
            result <= d_in;
      end
   end

endmodule
